counter_sched: RTL and testbench
================================

# counter_sched

Scheduler that time-shares one 4-bit up-counter between `NUM_REQ` requesters. Each requester asks for an interval of `target+1` counted cycles. A round-robin arbiter grants the counter to one requester at a time. The block then clears the counter, runs it up to that requester's target, and returns a one-cycle completion pulse. It sits between client blocks that need cycle-interval timing and the counter datapath, which it owns internally.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `CNT_W`, 4, counter width; targets range 0..2^CNT_W-1
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  NUM_REQ  per-requester level request; held until `done` or deliberately dropped to abort
- `target`  in  NUM_REQ*CNT_W  flattened targets; requester i uses bits [i*CNT_W +: CNT_W]
- `grant`  out  NUM_REQ  one-hot owner of the counter; all-zero when free
- `done`  out  NUM_REQ  one-cycle pulse to the owner on completion
- `busy`  out  1  high in RUN and DONE
- `count`  out  CNT_W  current counter value

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - If any `req` bit is set, pick the winner round-robin, searching upward from `last+1` modulo NUM_REQ.
  - At the clock edge: latch the winner index `idx` and `target_q`, set `count` to 0, set `grant[idx]`, set `last` to idx, go to RUN.
  - If no `req` bit is set, stay in IDLE.
- **RUN**
  - If `req[idx]` is 0: abort. Go to IDLE, clear `grant` and `count`, no `done` pulse.
  - Else if `count == target_q`: go to DONE, `count` holds.
  - Else: `count` increments by 1.
- **DONE**
  - `done[idx]` is 1 for exactly this cycle.
  - At the next edge: go to IDLE, clear `grant`, `count` holds its final value.
- `target` is sampled only at the grant edge. Changes during RUN are ignored.
- `count` never wraps, because `target_q` is at most 2^CNT_W-1.
- A requester that keeps `req` high after `done` is eligible again. Rotation gives the other pending requesters priority first.
- `req` bits of non-owners during RUN or DONE have no effect until IDLE.
- Reset values: state IDLE, `count`=0, `grant`=0, `done`=0, `busy`=0, `last`=NUM_REQ-1, so requester 0 has highest priority first.
- Reset asserted mid-operation forces all of the above immediately, with no `done` pulse.

## Timing
- Edge E0 is the grant edge, leaving IDLE.
- `count` equals k after edge Ek, for k = 0..T, where T is `target_q`.
- DONE is entered at edge E(T+1); `done` is high in the cycle following E(T+1).
- IDLE is re-entered at edge E(T+2).
- Grant-to-done latency is T+1 edges. The counter is owned for T+2 cycles.
- There is one mandatory IDLE cycle between consecutive grants. Back-to-back service period is T+3 cycles.
- An abort takes effect at the first edge where RUN samples `req[idx]`=0. `grant` drops one cycle after `req` drops.
- All outputs are registered. There is no combinational path from `req` or `target` to any output.

## Structure
- `counter_sched_pkg` holds:
  - the state enum `sched_state_t` (IDLE, RUN, DONE);
  - the default `CNT_W`;
  - the function returning the index of a one-hot vector.
- Sub-module `rr_arbiter`:
  - parameter `N`;
  - inputs: `req[N]`, `last` index;
  - outputs: combinational one-hot `gnt[N]` and `valid`.
- The FSM, counter and `last` register live in `counter_sched`.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `req`=4'b1111. Required: `grant`=0, `done`=0, `busy`=0, `count`=0 throughout.
- **Single request:**
  - Stimulus: `req[1]`=1, target1=3.
  - Required: `grant`=4'b0010 after E0; `count` 0,1,2,3 on E0..E3.
  - Required: `done`=4'b0010 for one cycle after E4; `grant`=0 after E5.
- **Boundary targets:**
  - target=0 gives `count` 0 and `done` after E1.
  - target=15 gives `count` 0..15 with no wrap, and `done` after E16.
- **Contention and rotation:**
  - Stimulus: `req`=4'b0101 held continuously from reset, both targets=1.
  - Required grant order: 0, 2, 0, 2.
  - Required: each service takes 4 cycles including the IDLE cycle, so grants are 4 cycles apart.
- **Abort:**
  - Stimulus: `req[3]`=1, target=10; drop `req[3]` when `count`=4.
  - Required: next edge returns to IDLE with `count`=0, `grant`=0, no `done`.
  - Required: a pending `req[0]` is granted on the following edge.
- **Reset mid-RUN:** assert `rst` when `count`=5. Required: outputs clear immediately without waiting for a clock edge, no `done` pulse, and requester 0 wins first after release.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the time-shared interval counter scheduler.
package counter_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;

  localparam int CNT_W_DEF = 4;

  // Index of the set bit in a one-hot vector (up to 8 requesters).
  function automatic int onehot_idx(input logic [7:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++)
      if (v[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search upward from last+1, wrapping at N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  int unsigned sel;
  logic        found;

  always_comb begin
    gnt   = '0;
    valid = |req;
    found = 1'b0;
    sel   = 0;
    for (int k = 1; k <= N; k++) begin
      sel = (int'(last) + k) % N;
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Grants a single up-counter round-robin to NUM_REQ requesters and pulses
// done when the owner's interval of target+1 counted cycles has elapsed.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] target,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t       state;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      last;
  logic [CNT_W-1:0]   target_q;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_valid;
  logic [IW-1:0]      win;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req   (req),
    .last  (last),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  assign win = IW'(onehot_idx(8'(arb_gnt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      last     <= IW'(NUM_REQ - 1);
      target_q <= '0;
      count    <= '0;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          // count keeps its last value here until the next grant clears it
          if (arb_valid) begin
            idx      <= win;
            last     <= win;
            target_q <= target[int'(win)*CNT_W +: CNT_W];
            count    <= '0;
            grant    <= arb_gnt;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (!req[idx]) begin
            grant <= '0;
            count <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (count == target_q) begin
            done  <= grant;
            state <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: table-driven vectors plus hand sequences
// for long targets, contention, abort and asynchronous reset.
module tb_counter_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] target;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [3:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  counter_sched #(.NUM_REQ(4), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .target (target),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .count  (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] tgt;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  count;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [3:0] g, input logic [3:0] d,
                         input logic b, input logic [3:0] c);
    chk({nm, ".grant"}, 32'(grant), 32'(g));
    chk({nm, ".done"},  32'(done),  32'(d));
    chk({nm, ".busy"},  32'(busy),  32'(b));
    chk({nm, ".count"}, 32'(count), 32'(c));
  endtask

  logic [3:0] gseq[4];
  int         gcyc[4];
  int         ng;
  logic [3:0] prev_g;

  initial begin
    // Inputs first, then expected outputs after the following edge.
    vt[0] = '{4'b0010, 16'h0030, 4'b0010, 4'b0000, 1'b1, 4'd0};
    vt[1] = '{4'b0010, 16'h0030, 4'b0010, 4'b0000, 1'b1, 4'd1};
    vt[2] = '{4'b0010, 16'h0030, 4'b0010, 4'b0000, 1'b1, 4'd2};
    vt[3] = '{4'b0010, 16'h0030, 4'b0010, 4'b0000, 1'b1, 4'd3};
    vt[4] = '{4'b0010, 16'h0030, 4'b0010, 4'b0010, 1'b1, 4'd3};
    vt[5] = '{4'b0000, 16'h0030, 4'b0000, 4'b0000, 1'b0, 4'd3};
    vt[6] = '{4'b0000, 16'h0030, 4'b0000, 4'b0000, 1'b0, 4'd3};
    vt[7] = '{4'b0100, 16'h0000, 4'b0100, 4'b0000, 1'b1, 4'd0};
    vt[8] = '{4'b0100, 16'h0000, 4'b0100, 4'b0100, 1'b1, 4'd0};
    vt[9] = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0};

    // Reset held with all requests asserted
    rst = 1'b1; req = 4'b1111; target = 16'hFFFF;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("reset%0d", i), 4'b0000, 4'b0000, 1'b0, 4'd0);
    end
    req = 4'b0000;
    rst = 1'b0;
    tick();
    chk_all("idle_after_reset", 4'b0000, 4'b0000, 1'b0, 4'd0);

    for (int i = 0; i < 10; i++) begin
      req = vt[i].req;
      target = vt[i].tgt;
      tick();
      chk_all($sformatf("vec%0d", i), vt[i].grant, vt[i].done, vt[i].busy, vt[i].count);
    end

    // Target 15 on requester 0: full range without wrap
    req = 4'b0001; target = 16'h000F;
    tick();
    chk_all("t15.grant", 4'b0001, 4'b0000, 1'b1, 4'd0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk_all($sformatf("t15.k%0d", k), 4'b0001, 4'b0000, 1'b1, 4'(k));
    end
    tick();
    chk_all("t15.done", 4'b0001, 4'b0001, 1'b1, 4'd15);
    req = 4'b0000;
    tick();
    chk_all("t15.release", 4'b0000, 4'b0000, 1'b0, 4'd15);

    // Contention: 0 and 2 held from reset, both targets 1
    rst = 1'b1; req = 4'b0101; target = 16'h0101;
    tick();
    rst = 1'b0;
    ng = 0; prev_g = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (grant != 4'b0000 && prev_g == 4'b0000 && ng < 4) begin
        gseq[ng] = grant;
        gcyc[ng] = c;
        ng++;
      end
      prev_g = grant;
    end
    chk("rr.count", 32'(ng), 32'd4);
    chk("rr.g0", 32'(gseq[0]), 32'h1);
    chk("rr.g1", 32'(gseq[1]), 32'h4);
    chk("rr.g2", 32'(gseq[2]), 32'h1);
    chk("rr.g3", 32'(gseq[3]), 32'h4);
    chk("rr.first_edge", 32'(gcyc[0]), 32'd0);
    for (int i = 1; i < 4; i++)
      chk($sformatf("rr.period%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd4);

    // Abort: requester 3 drops at count 4 while 0 is pending
    req = 4'b0000;
    rst = 1'b1; #1; rst = 1'b0;
    req = 4'b1000; target = 16'hA000;
    tick();
    chk_all("abort.grant", 4'b1000, 4'b0000, 1'b1, 4'd0);
    req = 4'b1001;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all($sformatf("abort.k%0d", k), 4'b1000, 4'b0000, 1'b1, 4'(k));
    end
    req = 4'b0001;
    tick();
    chk_all("abort.idle", 4'b0000, 4'b0000, 1'b0, 4'd0);
    tick();
    chk_all("abort.regrant", 4'b0001, 4'b0000, 1'b1, 4'd0);

    // Reset mid-RUN at count 5, cleared without a clock edge
    req = 4'b0000;
    rst = 1'b1; #1; rst = 1'b0;
    req = 4'b0100; target = 16'h0A00;
    tick();
    for (int k = 1; k <= 5; k++) tick();
    chk_all("midrst.pre", 4'b0100, 4'b0000, 1'b1, 4'd5);
    #2;
    req = 4'b0101;
    rst = 1'b1;
    #1;
    chk_all("midrst.async", 4'b0000, 4'b0000, 1'b0, 4'd0);
    tick();
    chk_all("midrst.held", 4'b0000, 4'b0000, 1'b0, 4'd0);
    rst = 1'b0;
    tick();
    chk_all("midrst.first", 4'b0001, 4'b0000, 1'b1, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
